// File: rtl/xorshift_checker_if.sv
// ============================================================================
// Interface : xorshift_checker_if
// Brief     : Stream input and status outputs of the xorshift stream checker.
// Options   : XSC_ERR_CAPTURE_EN adds cap_valid / cap_got / cap_exp.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

interface xorshift_checker_if #(
  parameter int ERR_W = 16
);
  logic             in_valid;
  logic [31:0]      in_data;
  logic             cnt_clr;
  logic             locked;
  logic             mismatch;
  logic [ERR_W-1:0] err_count;
  logic [31:0]      expected;
  logic [1:0]       state;
`ifdef XSC_ERR_CAPTURE_EN
  logic             cap_valid;
  logic [31:0]      cap_got;
  logic [31:0]      cap_exp;

  modport master (
    output in_valid, in_data, cnt_clr,
    input  locked, mismatch, err_count, expected, state,
    input  cap_valid, cap_got, cap_exp
  );

  modport slave (
    input  in_valid, in_data, cnt_clr,
    output locked, mismatch, err_count, expected, state,
    output cap_valid, cap_got, cap_exp
  );
`else
  modport master (
    output in_valid, in_data, cnt_clr,
    input  locked, mismatch, err_count, expected, state
  );

  modport slave (
    input  in_valid, in_data, cnt_clr,
    output locked, mismatch, err_count, expected, state
  );
`endif
endinterface

`default_nettype wire

// File: rtl/xorshift_checker.sv
// ============================================================================
// Module   : xorshift_checker
// Brief    : Self-synchronising checker for a 32-bit xorshift (13/17/5) stream.
// Options  : XSC_ERR_CAPTURE_EN captures the first locked mismatch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module xorshift_checker #(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int ERR_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  xorshift_checker_if.slave  bus
);

  localparam int c_LOCK_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
  localparam int c_LOSS_W = (LOSS_CNT > 1) ? $clog2(LOSS_CNT) : 1;
  localparam logic [c_LOCK_W-1:0] c_LOCK_LAST = c_LOCK_W'(LOCK_CNT - 1);
  localparam logic [c_LOSS_W-1:0] c_LOSS_LAST = c_LOSS_W'(LOSS_CNT - 1);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  function automatic logic [31:0] xs_next(input logic [31:0] x);
    logic [31:0] t1;
    logic [31:0] t2;
    t1 = x ^ (x << 13);
    t2 = t1 ^ (t1 >> 17);
    return t2 ^ (t2 << 5);
  endfunction

  state_t              r_state;
  logic                r_locked;
  logic                r_mismatch;
  logic [ERR_W-1:0]    r_err;
  logic [31:0]         r_expected;
  logic [c_LOCK_W-1:0] r_run;
  logic [c_LOSS_W-1:0] r_miss;

  logic [31:0] w_f_in;
  logic [31:0] w_f_exp;
  logic        w_in_zero;
  logic        w_in_hit;
  logic        w_lock_miss;

  assign w_f_in      = xs_next(bus.in_data);
  assign w_f_exp     = xs_next(r_expected);
  assign w_in_zero   = (bus.in_data == 32'd0);
  assign w_in_hit    = (bus.in_data == r_expected);
  assign w_lock_miss = bus.in_valid && (r_state == ST_LOCKED) && !w_in_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_HUNT;
      r_locked   <= 1'b0;
      r_mismatch <= 1'b0;
      r_err      <= '0;
      r_expected <= '0;
      r_run      <= '0;
      r_miss     <= '0;
    end else begin
      r_mismatch <= w_lock_miss;

      // A clear coinciding with a counted mismatch keeps that one mismatch.
      if (bus.cnt_clr) begin
        r_err <= w_lock_miss ? ERR_W'(1) : '0;
      end else if (w_lock_miss && (r_err != '1)) begin
        r_err <= r_err + ERR_W'(1);
      end

      if (bus.in_valid) begin
        case (r_state)
          ST_HUNT: begin
            if (!w_in_zero) begin
              r_expected <= w_f_in;
              r_run      <= '0;
              r_state    <= ST_SYNC;
            end
          end
          ST_SYNC: begin
            if (w_in_hit) begin
              r_expected <= w_f_in;
              if (r_run == c_LOCK_LAST) begin
                r_state  <= ST_LOCKED;
                r_locked <= 1'b1;
                r_run    <= '0;
                r_miss   <= '0;
              end else begin
                r_run <= r_run + c_LOCK_W'(1);
              end
            end else if (!w_in_zero) begin
              r_expected <= w_f_in;
              r_run      <= '0;
            end else begin
              r_state    <= ST_HUNT;
              r_expected <= '0;
              r_run      <= '0;
            end
          end
          ST_LOCKED: begin
            // Prediction free-runs; a bad word never reseeds it.
            if (w_in_hit) begin
              r_expected <= w_f_exp;
              r_miss     <= '0;
            end else if (r_miss == c_LOSS_LAST) begin
              r_state    <= ST_HUNT;
              r_locked   <= 1'b0;
              r_expected <= '0;
              r_miss     <= '0;
            end else begin
              r_expected <= w_f_exp;
              r_miss     <= r_miss + c_LOSS_W'(1);
            end
          end
          default: begin
            r_state    <= ST_HUNT;
            r_locked   <= 1'b0;
            r_expected <= '0;
            r_run      <= '0;
            r_miss     <= '0;
          end
        endcase
      end
    end
  end

  assign bus.locked    = r_locked;
  assign bus.mismatch  = r_mismatch;
  assign bus.err_count = r_err;
  assign bus.expected  = r_expected;
  assign bus.state     = r_state;

`ifdef XSC_ERR_CAPTURE_EN
  logic        r_cap_valid;
  logic [31:0] r_cap_got;
  logic [31:0] r_cap_exp;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cap_valid <= 1'b0;
      r_cap_got   <= '0;
      r_cap_exp   <= '0;
    end else if (w_lock_miss && (bus.cnt_clr || !r_cap_valid)) begin
      r_cap_valid <= 1'b1;
      r_cap_got   <= bus.in_data;
      r_cap_exp   <= r_expected;
    end else if (bus.cnt_clr) begin
      r_cap_valid <= 1'b0;
      r_cap_got   <= '0;
      r_cap_exp   <= '0;
    end
  end

  assign bus.cap_valid = r_cap_valid;
  assign bus.cap_got   = r_cap_got;
  assign bus.cap_exp   = r_cap_exp;
`endif

endmodule

`default_nettype wire

// File: tb/tb_xorshift_checker.sv
// ============================================================================
// Module   : tb_xorshift_checker
// Brief    : Directed self-checking bench for xorshift_checker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xorshift_checker;

  // Narrow error counter so saturation is reachable in a short run.
  localparam int TB_ERR_W = 4;
  localparam logic [TB_ERR_W-1:0] c_ERR_MAX = '1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  xorshift_checker_if #(.ERR_W(TB_ERR_W)) bus ();

  xorshift_checker #(
    .LOCK_CNT (4),
    .LOSS_CNT (3),
    .ERR_W    (TB_ERR_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] cur;
  logic [31:0] w;

  function automatic logic [31:0] fx(input logic [31:0] x);
    logic [31:0] a;
    logic [31:0] b;
    a = x ^ {x[18:0], 13'd0};
    b = a ^ {17'd0, a[31:17]};
    return b ^ {b[26:0], 5'd0};
  endfunction

  task automatic step(input logic v, input logic [31:0] d);
    bus.in_valid = v;
    bus.in_data  = d;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1'b1, 32'h1234_5678);
    rst = 1'b0;
    total++; if (bus.state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", bus.state); end
    total++; if (bus.locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%b want=0", bus.locked); end
    total++; if (bus.mismatch !== 1'b0) begin bad++; $display("FAIL reset_mismatch got=%b want=0", bus.mismatch); end
    total++; if (bus.err_count !== '0) begin bad++; $display("FAIL reset_err got=%h want=0", bus.err_count); end
    total++; if (bus.expected !== 32'd0) begin bad++; $display("FAIL reset_expected got=%h want=0", bus.expected); end
  endtask

  task automatic test_lock();
    step(1'b1, 32'd0);
    total++; if (bus.state !== 2'd0) begin bad++; $display("FAIL hunt_zero got=%0d want=0", bus.state); end
    step(1'b1, 32'h0000_0001);
    total++; if (bus.state !== 2'd1) begin bad++; $display("FAIL sync_entry got=%0d want=1", bus.state); end
    total++; if (bus.expected !== 32'h0004_2021) begin bad++; $display("FAIL f_of_1 got=%h want=00042021", bus.expected); end
    step(1'b1, 32'h0004_2021);
    total++; if (bus.expected !== 32'h0408_0601) begin bad++; $display("FAIL f_of_42021 got=%h want=04080601", bus.expected); end
    step(1'b1, 32'h0408_0601);
    cur = 32'h0408_0601;
    step(1'b1, fx(cur));
    cur = fx(cur);
    total++; if (bus.state !== 2'd1 || bus.locked !== 1'b0) begin bad++; $display("FAIL sync_3rd got=%0d/%b want=1/0", bus.state, bus.locked); end
    step(1'b1, fx(cur));
    cur = fx(cur);
    total++; if (bus.state !== 2'd2 || bus.locked !== 1'b1) begin bad++; $display("FAIL lock_4th got=%0d/%b want=2/1", bus.state, bus.locked); end
    total++; if (bus.err_count !== '0 || bus.mismatch !== 1'b0) begin bad++; $display("FAIL lock_err got=%h/%b want=0/0", bus.err_count, bus.mismatch); end
    total++; if (bus.expected !== fx(cur)) begin bad++; $display("FAIL lock_expected got=%h want=%h", bus.expected, fx(cur)); end
  endtask

  task automatic test_single_error();
    w = fx(cur);
    step(1'b1, w ^ 32'h1);
    cur = w;
    total++; if (bus.mismatch !== 1'b1) begin bad++; $display("FAIL single_pulse got=%b want=1", bus.mismatch); end
    total++; if (bus.err_count !== 4'd1) begin bad++; $display("FAIL single_err got=%0d want=1", bus.err_count); end
    total++; if (bus.state !== 2'd2) begin bad++; $display("FAIL single_state got=%0d want=2", bus.state); end
    total++; if (bus.expected !== fx(cur)) begin bad++; $display("FAIL single_freerun got=%h want=%h", bus.expected, fx(cur)); end
`ifdef XSC_ERR_CAPTURE_EN
    total++; if (bus.cap_valid !== 1'b1 || bus.cap_exp !== w || bus.cap_got !== (w ^ 32'h1)) begin
      bad++; $display("FAIL single_cap got=%b/%h/%h want=1/%h/%h", bus.cap_valid, bus.cap_got, bus.cap_exp, w ^ 32'h1, w);
    end
`endif
    step(1'b1, fx(cur));
    cur = fx(cur);
    total++; if (bus.mismatch !== 1'b0 || bus.locked !== 1'b1) begin bad++; $display("FAIL single_recover got=%b/%b want=0/1", bus.mismatch, bus.locked); end
  endtask

  task automatic test_gaps();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'hDEAD_0000 + i);
      total++; if (bus.state !== 2'd2 || bus.expected !== fx(cur) || bus.mismatch !== 1'b0) begin
        bad++; $display("FAIL gap_%0d got=%0d/%h/%b want=2/%h/0", i, bus.state, bus.expected, bus.mismatch, fx(cur));
      end
      step(1'b1, fx(cur));
      cur = fx(cur);
      total++; if (bus.mismatch !== 1'b0 || bus.locked !== 1'b1) begin bad++; $display("FAIL gap_word_%0d got=%b/%b want=0/1", i, bus.mismatch, bus.locked); end
    end
  endtask

  task automatic test_loss();
    bus.cnt_clr = 1'b1;
    step(1'b0, 32'd0);
    bus.cnt_clr = 1'b0;
    total++; if (bus.err_count !== '0 || bus.state !== 2'd2 || bus.expected !== fx(cur)) begin
      bad++; $display("FAIL clr_idle got=%h/%0d/%h want=0/2/%h", bus.err_count, bus.state, bus.expected, fx(cur));
    end
`ifdef XSC_ERR_CAPTURE_EN
    total++; if (bus.cap_valid !== 1'b0) begin bad++; $display("FAIL clr_cap got=%b want=0", bus.cap_valid); end
`endif
    for (int i = 0; i < 3; i++) begin
      step(1'b1, fx(cur) ^ 32'hFFFF_0000);
      cur = fx(cur);
      total++; if (bus.mismatch !== 1'b1 || bus.err_count !== 4'(i + 1)) begin
        bad++; $display("FAIL loss_%0d got=%b/%0d want=1/%0d", i, bus.mismatch, bus.err_count, i + 1);
      end
      if (i < 2) begin
        total++; if (bus.state !== 2'd2) begin bad++; $display("FAIL loss_hold_%0d got=%0d want=2", i, bus.state); end
      end
    end
    total++; if (bus.state !== 2'd0 || bus.locked !== 1'b0 || bus.expected !== 32'd0) begin
      bad++; $display("FAIL loss_hunt got=%0d/%b/%h want=0/0/0", bus.state, bus.locked, bus.expected);
    end
    step(1'b0, 32'd0);
    total++; if (bus.mismatch !== 1'b0) begin bad++; $display("FAIL loss_pulse_end got=%b want=0", bus.mismatch); end
  endtask

  task automatic test_reseed();
    step(1'b1, 32'h0000_0001);
    step(1'b1, 32'hDEAD_BEEF);
    cur = 32'hDEAD_BEEF;
    total++; if (bus.state !== 2'd1 || bus.expected !== fx(cur)) begin
      bad++; $display("FAIL reseed got=%0d/%h want=1/%h", bus.state, bus.expected, fx(cur));
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, fx(cur));
      cur = fx(cur);
      total++; if (bus.state !== 2'd1) begin bad++; $display("FAIL reseed_run_%0d got=%0d want=1", i, bus.state); end
    end
    step(1'b1, fx(cur));
    cur = fx(cur);
    total++; if (bus.state !== 2'd2 || bus.locked !== 1'b1) begin bad++; $display("FAIL reseed_lock got=%0d/%b want=2/1", bus.state, bus.locked); end
    total++; if (bus.err_count !== 4'd3) begin bad++; $display("FAIL sync_nocount got=%0d want=3", bus.err_count); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 12; i++) begin
      step(1'b1, fx(cur) ^ 32'h0000_0100);
      cur = fx(cur);
      step(1'b1, fx(cur));
      cur = fx(cur);
    end
    total++; if (bus.err_count !== c_ERR_MAX || bus.state !== 2'd2) begin
      bad++; $display("FAIL sat_reach got=%0d/%0d want=%0d/2", bus.err_count, bus.state, c_ERR_MAX);
    end
    step(1'b1, fx(cur) ^ 32'h0000_0100);
    cur = fx(cur);
    total++; if (bus.err_count !== c_ERR_MAX || bus.mismatch !== 1'b1) begin
      bad++; $display("FAIL sat_hold got=%0d/%b want=%0d/1", bus.err_count, bus.mismatch, c_ERR_MAX);
    end
    step(1'b1, fx(cur));
    cur = fx(cur);
  endtask

  task automatic test_clr_coincide();
    w = fx(cur);
    bus.cnt_clr = 1'b1;
    step(1'b1, w ^ 32'h0000_0080);
    bus.cnt_clr = 1'b0;
    cur = w;
    total++; if (bus.err_count !== 4'd1 || bus.mismatch !== 1'b1) begin
      bad++; $display("FAIL clr_coincide got=%0d/%b want=1/1", bus.err_count, bus.mismatch);
    end
`ifdef XSC_ERR_CAPTURE_EN
    total++; if (bus.cap_valid !== 1'b1 || bus.cap_exp !== w || bus.cap_got !== (w ^ 32'h80)) begin
      bad++; $display("FAIL clr_cap_new got=%b/%h/%h want=1/%h/%h", bus.cap_valid, bus.cap_got, bus.cap_exp, w ^ 32'h80, w);
    end
`endif
    step(1'b1, fx(cur));
    cur = fx(cur);
    total++; if (bus.locked !== 1'b1 || bus.err_count !== 4'd1) begin bad++; $display("FAIL clr_after got=%b/%0d want=1/1", bus.locked, bus.err_count); end
  endtask

  task automatic test_mid_reset();
    rst = 1'b1;
    step(1'b1, fx(cur) ^ 32'h4);
    rst = 1'b0;
    total++; if (bus.state !== 2'd0 || bus.locked !== 1'b0 || bus.mismatch !== 1'b0 || bus.err_count !== '0 || bus.expected !== 32'd0) begin
      bad++; $display("FAIL mid_reset got=%0d/%b/%b/%0d/%h want=0/0/0/0/0", bus.state, bus.locked, bus.mismatch, bus.err_count, bus.expected);
    end
`ifdef XSC_ERR_CAPTURE_EN
    total++; if (bus.cap_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_cap got=%b want=0", bus.cap_valid); end
`endif
    step(1'b1, 32'h0000_0005);
    step(1'b1, 32'd0);
    total++; if (bus.state !== 2'd0 || bus.expected !== 32'd0) begin
      bad++; $display("FAIL sync_zero got=%0d/%h want=0/0", bus.state, bus.expected);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 32'd0;
    bus.cnt_clr  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_lock();
    test_single_error();
    test_gaps();
    test_loss();
    test_reseed();
    test_saturation();
    test_clr_coincide();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
